// File: rtl/otp_decryptor.sv
// otp_decryptor: receive side of the one-time-pad link.
// It regenerates the sender's LFSR pad stream from a shared seed and keeps the
// last eight pads in a ring. Each tagged ciphertext byte is XORed with its
// matching pad. A tag that does not match the expected ring slot means the pad
// streams have drifted apart. The block then stops accepting bytes until a
// resync pulse refills the ring from the seed.
// Optional build macro OTP_ERRCNT_EN adds the err_count output, which is a
// saturating count of mismatched tags. Only rst clears it.
module otp_decryptor #(
    parameter logic [7:0] SEED  = 8'h01,
    parameter int         DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic [2:0] in_tag,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       resync,
    output logic       err,
    output logic       busy
`ifdef OTP_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [2:0] LAST_SLOT = 3'(DEPTH - 1);

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] lfsr_next;
    logic [2:0] fill_ptr;
    logic [2:0] exp_ptr;
    logic [2:0] tag_slot;
    logic [7:0] ring [DEPTH];
    logic       accept;
    logic       tag_ok;
    logic       drain;

    // The sender's tag is its post-increment count, so the slot it used is one behind.
    assign tag_slot  = in_tag - 3'd1;
    assign tag_ok    = (tag_slot == exp_ptr);
    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // The output register can take a new byte in the same cycle it drains.
    // A resync in the same cycle blocks the handshake.
    assign in_ready = (state == RUN) && !resync && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign busy     = (state == FILL);

    // Main controller: ring fill, decryption, tag checking and resynchronisation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            lfsr      <= SEED;
            fill_ptr  <= 3'd0;
            exp_ptr   <= 3'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ring[i] <= 8'h00;
            end
        end else if (resync) begin
            state     <= FILL;
            lfsr      <= SEED;
            fill_ptr  <= 3'd0;
            exp_ptr   <= 3'd0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    ring[fill_ptr] <= lfsr;
                    lfsr           <= lfsr_next;
                    fill_ptr       <= fill_ptr + 3'd1;
                    if (fill_ptr == LAST_SLOT) begin
                        state <= RUN;
                    end
                    if (drain) begin
                        out_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept && tag_ok) begin
                        out_data      <= in_data ^ ring[exp_ptr];
                        out_valid     <= 1'b1;
                        ring[exp_ptr] <= lfsr;
                        lfsr          <= lfsr_next;
                        exp_ptr       <= exp_ptr + 3'd1;
                    end else begin
                        if (drain) begin
                            out_valid <= 1'b0;
                        end
                        if (accept) begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                ERR: begin
                    if (drain) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

`ifdef OTP_ERRCNT_EN
    // Count the mismatched tags and saturate at 0xFF. A resync leaves this history intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 8'h00;
        end else if (state == RUN && accept && !tag_ok && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_otp_decryptor.sv
// tb_otp_decryptor: directed scenarios followed by random traffic.
// The expected values come from a behavioural model of the decryptor. The model
// treats byte n after a resync as decrypted with the n-th pad of the seed stream.
module tb_otp_decryptor;

    localparam logic [7:0] SEED = 8'h01;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic [2:0] in_tag;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       resync;
    logic       err;
    logic       busy;
`ifdef OTP_ERRCNT_EN
    logic [7:0] err_count;
`endif

    otp_decryptor #(.SEED(SEED), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resync    (resync),
        .err       (err),
        .busy      (busy)
`ifdef OTP_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         m_fill_left;
    bit         m_err;
    bit         m_ov;
    logic [7:0] m_od;
    int         m_cnt;
    int         m_errcnt;

    // n-th pad of the stream (n = 0 is the seed itself)
    function automatic logic [7:0] pad_at(input int n);
        logic [7:0] q;
        q = SEED;
        repeat (n) q = {q[6:0], ^(q & 8'hB8)};
        return q;
    endfunction

    function automatic logic [2:0] next_tag();
        return 3'((m_cnt + 1) % 8);
    endfunction

    function automatic bit model_ready();
        return (m_fill_left == 0) && !m_err && !resync && (!m_ov || out_ready);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied
    task automatic modelStep();
        bit rdy;
        rdy = model_ready();
        if (rst) begin
            m_fill_left = 8; m_err = 0; m_ov = 0; m_od = 8'h00; m_cnt = 0; m_errcnt = 0;
        end else if (resync) begin
            m_fill_left = 8; m_err = 0; m_ov = 0; m_cnt = 0;
        end else if (m_fill_left > 0) begin
            m_fill_left--;
            if (m_ov && out_ready) m_ov = 0;
        end else if (in_valid && rdy && in_tag == next_tag()) begin
            m_od = in_data ^ pad_at(m_cnt);
            m_ov = 1;
            m_cnt++;
        end else begin
            if (m_ov && out_ready) m_ov = 0;
            if (in_valid && rdy) begin
                m_err = 1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
    endtask

    // Drive one cycle of inputs, check in_ready before the edge and the registered outputs after it
    task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d,
                                 input logic [2:0] t, input bit ordy, input bit rs);
        rst = r; in_valid = v; in_data = d; in_tag = t; out_ready = ordy; resync = rs;
        #1;
        if (!r) checkOutput("in_ready", in_ready, model_ready());
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("out_valid", out_valid, m_ov);
        checkOutput("out_data", out_data, m_od);
        checkOutput("err", err, m_err);
        checkOutput("busy", busy, m_fill_left > 0);
`ifdef OTP_ERRCNT_EN
        checkOutput("err_count", err_count, m_errcnt);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 8'h00, 3'd0, 1, 0);
    endtask

    logic [7:0] first_pads [6];

    initial begin
        first_pads = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
        rst = 0; in_valid = 0; in_data = 0; in_tag = 0; out_ready = 1; resync = 0;
        m_fill_left = 8; m_err = 0; m_ov = 0; m_od = 0; m_cnt = 0; m_errcnt = 0;

        // Reset, then the ring fills for eight cycles
        applyStimulus(1, 0, 8'h00, 3'd0, 1, 0);
        checkOutput("reset_busy", busy, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        idle(7);
        checkOutput("fill_busy_7", busy, 1);
        idle(1);
        checkOutput("fill_done_busy", busy, 0);
        #1 checkOutput("fill_done_ready", in_ready, 1);

        // Three known bytes with latency 1
        applyStimulus(0, 1, 8'h41, 3'd1, 1, 0);
        checkOutput("plan_b0", out_data, 8'h40);
        applyStimulus(0, 1, 8'h43, 3'd2, 1, 0);
        checkOutput("plan_b1", out_data, 8'h41);
        applyStimulus(0, 1, 8'h0C, 3'd3, 1, 0);
        checkOutput("plan_b2", out_data, 8'h08);
        idle(1);

        // Sixteen zero bytes expose the raw pads, including the pads after the wrap
        applyStimulus(0, 0, 8'h00, 3'd0, 1, 1);
        idle(8);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 8'h00, 3'((i + 1) % 8), 1, 0);
            if (i < 6) checkOutput("pad_seq", out_data, first_pads[i]);
        end
        checkOutput("pad16_err", err, 0);

        // Backpressure: the held byte stays stable and is never lost
        applyStimulus(0, 1, 8'h5A, next_tag(), 1, 0);
        applyStimulus(0, 1, 8'h77, next_tag(), 0, 0);
        applyStimulus(0, 1, 8'h77, next_tag(), 0, 0);
        checkOutput("bp_hold_valid", out_valid, 1);
        applyStimulus(0, 1, 8'h77, next_tag(), 1, 0);
        checkOutput("bp_release", out_data, 8'h77 ^ pad_at(m_cnt - 1));
        idle(1);

        // A tag mismatch sets err and stalls the block until a resync
        applyStimulus(0, 0, 8'h00, 3'd0, 1, 1);
        idle(8);
        applyStimulus(0, 1, 8'h41, 3'd3, 1, 0);
        checkOutput("mm_err", err, 1);
        checkOutput("mm_no_valid", out_valid, 0);
        applyStimulus(0, 1, 8'h41, 3'd1, 1, 0);
        checkOutput("mm_stalled", out_valid, 0);
        applyStimulus(0, 0, 8'h00, 3'd0, 1, 1);
        checkOutput("rs_err_clear", err, 0);
        idle(8);
        applyStimulus(0, 1, 8'h41, 3'd1, 1, 0);
        checkOutput("rs_first", out_data, 8'h40);
`ifdef OTP_ERRCNT_EN
        checkOutput("errcnt_one", err_count, 1);
`endif

        // A resync takes priority over a byte offered in the same cycle
        applyStimulus(0, 1, 8'h43, 3'd2, 1, 1);
        checkOutput("rs_prio_busy", busy, 1);
        idle(8);
        applyStimulus(0, 1, 8'h41, 3'd1, 1, 0);
        checkOutput("rs_prio_ptr0", out_data, 8'h40);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            bit r, v, ordy, rs;
            logic [2:0] t;
            r    = ($urandom_range(0, 299) == 0);
            rs   = ($urandom_range(0, 59) == 0);
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            t    = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : next_tag();
            applyStimulus(r, v, 8'($urandom_range(0, 255)), t, ordy, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
